// File: rtl/aurora_idle_pkg.sv
// Shared types and constants for the multi-lane Aurora idle/CC sequencer.
// Also holds the per-lane LFSR seed rule, so every lane starts on a distinct phase.
package aurora_idle_pkg;

   typedef enum logic [1:0] {
      ST_DATA = 2'd0,
      ST_IDLE = 2'd1,
      ST_CC   = 2'd2
   } state_t;

   localparam int              LFSR_W         = 7;
   // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of the shift register).
   localparam logic [LFSR_W-1:0] LFSR_TAPS      = 7'b110_0000;
   localparam logic [LFSR_W-1:0] LFSR_SEED_BASE = 7'h5A;

   function automatic logic [LFSR_W-1:0] lfsr_seed(input int lane);
      logic [LFSR_W-1:0] s;
      s = LFSR_SEED_BASE ^ LFSR_W'(lane);
      if (s == '0) begin
         s = 7'h01;
      end
      return s;
   endfunction

endpackage

// File: rtl/aurora_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR; one instance per lane supplies the K/R choice.
module aurora_lfsr7
   import aurora_idle_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LFSR_W-1:0] seed,
   output logic              lfsr_bit,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] value_reg;
   logic [LFSR_W-1:0] value_next;

   always_comb begin
      value_next = {value_reg[LFSR_W-2:0], ^(value_reg & LFSR_TAPS)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_reg <= seed;
      end else begin
         value_reg <= value_next;
      end
   end

   assign value    = value_reg;
   assign lfsr_bit = value_reg[LFSR_W-1];

endmodule

// File: rtl/aurora_idle_sequencer.sv
// Multi-lane Aurora idle generator: per-lane K/R, lane-aligned A columns at random
// spacing, and periodic clock-compensation sequences that pre-empt idle and data.
module aurora_idle_sequencer
   import aurora_idle_pkg::*;
#(
   parameter int LANES        = 2,
   parameter int A_MIN        = 16,
   parameter int A_RANGE_BITS = 4,
   parameter int CC_PERIOD    = 5000,
   parameter int CC_LEN       = 6
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             send_idle,
   input  logic             cc_enable,
   output logic [LANES-1:0] send_K,
   output logic [LANES-1:0] send_A,
   output logic [LANES-1:0] send_R,
   output logic [LANES-1:0] send_CC,
   output logic             cc_active
);

   localparam int CNT_W = $clog2(A_MIN + 2**A_RANGE_BITS);
   localparam int TMR_W = $clog2(CC_PERIOD);
   localparam int CCC_W = $clog2(CC_LEN + 1);

   state_t                         state_reg, state_next;
   logic [CNT_W-1:0]               cnt_reg, cnt_next;
   logic [TMR_W-1:0]               cc_timer_reg, cc_timer_next;
   logic                           cc_pending_reg, cc_pending_next;
   logic [CCC_W-1:0]               cc_count_reg, cc_count_next;
   logic                           send_idle_q_reg;
   logic [LANES-1:0]               k_reg, k_next;
   logic [LANES-1:0]               a_reg, a_next;
   logic [LANES-1:0]               r_reg, r_next;
   logic [LANES-1:0]               cc_reg, cc_next;
   logic                           active_reg, active_next;
   logic                           cc_start;

   logic [LANES-1:0]               rand_bits;
   logic [LANES-1:0][LFSR_W-1:0]   lfsr_values;
   logic [A_RANGE_BITS-1:0]        gap_extra;
   logic                           lfsr_unused;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         aurora_lfsr7 u_lfsr (
            .clk      (clk),
            .rst      (rst),
            .seed     (lfsr_seed(gi)),
            .lfsr_bit (rand_bits[gi]),
            .value    (lfsr_values[gi])
         );
      end
   endgenerate

   // Only lane 0's low bits feed the A spacing; the rest are deliberately ignored.
   assign gap_extra   = lfsr_values[0][A_RANGE_BITS-1:0];
   assign lfsr_unused = ^lfsr_values;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      cc_count_next = cc_count_reg;
      k_next        = '0;
      a_next        = '0;
      r_next        = '0;
      cc_next       = '0;
      active_next   = 1'b0;
      cc_start      = 1'b0;

      if (state_reg == ST_CC && cc_count_reg != CCC_W'(CC_LEN - 1)) begin
         // A started CC always runs to completion, whatever the inputs do.
         state_next    = ST_CC;
         cc_count_next = cc_count_reg + 1'b1;
         cc_next       = '1;
         active_next   = 1'b1;
      end else if (cc_pending_reg && cc_enable) begin
         state_next    = ST_CC;
         cc_count_next = '0;
         cc_next       = '1;
         active_next   = 1'b1;
         cc_start      = 1'b1;
      end else if (send_idle) begin
         state_next = ST_IDLE;
         if (!send_idle_q_reg || cnt_reg == '0) begin
            a_next   = '1;
            cnt_next = CNT_W'(A_MIN) + CNT_W'(gap_extra);
         end else begin
            cnt_next = cnt_reg - 1'b1;
            k_next   = rand_bits;
            r_next   = ~rand_bits;
         end
      end else begin
         state_next = ST_DATA;
      end
   end

   always_comb begin
      cc_timer_next   = '0;
      cc_pending_next = 1'b0;
      if (cc_enable) begin
         cc_pending_next = cc_start ? 1'b0 : cc_pending_reg;
         if (cc_timer_reg == TMR_W'(CC_PERIOD - 1)) begin
            cc_timer_next   = '0;
            cc_pending_next = 1'b1;
         end else begin
            cc_timer_next = cc_timer_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_DATA;
         cnt_reg         <= '0;
         cc_timer_reg    <= '0;
         cc_pending_reg  <= 1'b0;
         cc_count_reg    <= '0;
         send_idle_q_reg <= 1'b0;
         k_reg           <= '0;
         a_reg           <= '0;
         r_reg           <= '0;
         cc_reg          <= '0;
         active_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         cc_timer_reg    <= cc_timer_next;
         cc_pending_reg  <= cc_pending_next;
         cc_count_reg    <= cc_count_next;
         send_idle_q_reg <= send_idle;
         k_reg           <= k_next;
         a_reg           <= a_next;
         r_reg           <= r_next;
         cc_reg          <= cc_next;
         active_reg      <= active_next;
      end
   end

   assign send_K    = k_reg;
   assign send_A    = a_reg;
   assign send_R    = r_reg;
   assign send_CC   = cc_reg;
   assign cc_active = active_reg;

endmodule

// File: tb/tb_aurora_idle_sequencer.sv
// Randomised bench for aurora_idle_sequencer against a gap/schedule reference model.
module tb_aurora_idle_sequencer;

   localparam int LANES        = 2;
   localparam int A_MIN        = 16;
   localparam int A_RANGE_BITS = 4;
   localparam int CC_PERIOD    = 64;
   localparam int CC_LEN       = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             send_idle;
   logic             cc_enable;
   logic [LANES-1:0] send_K, send_A, send_R, send_CC;
   logic             cc_active;

   aurora_idle_sequencer #(
      .LANES        (LANES),
      .A_MIN        (A_MIN),
      .A_RANGE_BITS (A_RANGE_BITS),
      .CC_PERIOD    (CC_PERIOD),
      .CC_LEN       (CC_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .send_idle (send_idle),
      .cc_enable (cc_enable),
      .send_K    (send_K),
      .send_A    (send_A),
      .send_R    (send_R),
      .send_CC   (send_CC),
      .cc_active (cc_active)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // Reference model: A spacing tracked as "non-A idle cycles since last A" against
   // a drawn target; CC tracked as a schedule of enabled cycles and remaining length.
   logic [6:0]       m_lfsr [LANES];
   bit               m_siq;
   int               m_nona, m_target;
   int               m_timer, m_cc_left;
   bit               m_pending;
   logic [LANES-1:0] e_k, e_a, e_r, e_cc;
   logic             e_act;

   task automatic model_reset();
      for (int i = 0; i < LANES; i++) begin
         m_lfsr[i] = 7'h5A ^ 7'(i);
         if (m_lfsr[i] == 7'd0) m_lfsr[i] = 7'h01;
      end
      m_siq = 0; m_nona = 0; m_target = 0;
      m_timer = 0; m_cc_left = 0; m_pending = 0;
      e_k = '0; e_a = '0; e_r = '0; e_cc = '0; e_act = 1'b0;
   endtask

   task automatic model_edge(input bit si, input bit ce);
      int r;
      bit start;
      r = int'(m_lfsr[0]) % (1 << A_RANGE_BITS);
      start = 0;
      e_k = '0; e_a = '0; e_r = '0; e_cc = '0; e_act = 1'b0;
      if (m_cc_left > 0) begin
         e_cc = '1; e_act = 1'b1; m_cc_left--;
      end else if (m_pending && ce) begin
         e_cc = '1; e_act = 1'b1; m_cc_left = CC_LEN - 1; start = 1;
      end else if (si) begin
         if (!m_siq || m_nona == m_target) begin
            e_a = '1; m_target = A_MIN + r; m_nona = 0;
         end else begin
            for (int i = 0; i < LANES; i++) begin
               e_k[i] = m_lfsr[i][6];
               e_r[i] = !m_lfsr[i][6];
            end
            m_nona++;
         end
      end
      m_siq = si;
      if (!ce) begin
         m_timer = 0; m_pending = 0;
      end else begin
         if (start) m_pending = 0;
         m_timer++;
         if (m_timer == CC_PERIOD) begin
            m_timer = 0; m_pending = 1;
         end
      end
      for (int i = 0; i < LANES; i++)
         m_lfsr[i] = {m_lfsr[i][5:0], m_lfsr[i][6] ^ m_lfsr[i][5]};
   endtask

   task automatic compare_outputs();
      logic [LANES-1:0] all1;
      all1 = '1;
      check("send_K", 32'(send_K), 32'(e_k));
      check("send_A", 32'(send_A), 32'(e_a));
      check("send_R", 32'(send_R), 32'(e_r));
      check("send_CC", 32'(send_CC), 32'(e_cc));
      check("cc_active", 32'(cc_active), 32'(e_act));
      for (int i = 0; i < LANES; i++) begin
         int n;
         n = int'(send_K[i]) + int'(send_A[i]) + int'(send_R[i]) + int'(send_CC[i]);
         check("lane_onehot", 32'(n <= 1), 32'd1);
      end
      check("A_uniform", 32'(send_A == '0 || send_A == all1), 32'd1);
      check("CC_uniform", 32'(send_CC == '0 || send_CC == all1), 32'd1);
   endtask

   // Called at a falling edge: drive, take one rising edge, then check.
   task automatic cycle(input bit si, input bit ce);
      send_idle = si;
      cc_enable = ce;
      @(posedge clk);
      model_edge(si, ce);
      cyc++;
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic reset_hold(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_outputs", 32'({send_K, send_A, send_R, send_CC, cc_active}), 32'd0);
      end
   endtask

   bit have_a;
   int gap;

   task automatic track_gap();
      logic [LANES-1:0] all1;
      all1 = '1;
      if (send_A != '0) begin
         if (have_a) check("A_gap_range", 32'(gap >= A_MIN && gap <= A_MIN + 15), 32'd1);
         have_a = 1;
         gap = 0;
      end else if ((send_K | send_R) != '0) begin
         check("KR_exclusive", 32'(send_K ^ send_R), 32'(all1));
         gap++;
      end
   endtask

   initial begin
      bit differ, prev_act, found, seen, si_cur, ce_cur;
      int start_prev, run, nstarts, len;

      rst = 1'b1; send_idle = 1'b1; cc_enable = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_outputs", 32'({send_K, send_A, send_R, send_CC, cc_active}), 32'd0);
      reset_hold(5);
      rst = 1'b0;

      repeat (100) cycle(0, 0);

      // Idle entry and A cadence.
      cycle(1, 0);
      check("first_idle_A", 32'(send_A), 32'h3);
      have_a = 1; gap = 0; differ = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1, 0);
         track_gap();
         if (send_K[0] != send_K[1]) differ = 1;
      end
      check("lanes_differ", 32'(differ), 32'd1);
      repeat (200) begin cycle(1, 0); track_gap(); end
      repeat (5) cycle(0, 0);

      // CC cadence with cc_enable high from reset.
      @(negedge clk);
      rst = 1'b1; send_idle = 1'b0; cc_enable = 1'b1;
      model_reset();
      reset_hold(3);
      rst = 1'b0;
      prev_act = 0; start_prev = -1; run = 0; nstarts = 0;
      repeat (300) begin
         cycle(0, 1);
         if (cc_active) begin
            if (!prev_act) begin
               if (start_prev >= 0) check("cc_spacing", 32'(cyc - start_prev), 32'(CC_PERIOD));
               start_prev = cyc; nstarts++; run = 0;
            end
            run++;
         end else if (prev_act) begin
            check("cc_len", 32'(run), 32'(CC_LEN));
         end
         prev_act = cc_active;
      end
      check("cc_starts_seen", 32'(nstarts >= 3), 32'd1);

      // CC interleaved with a held idle request.
      have_a = 0; gap = 0;
      repeat (500) begin cycle(1, 1); track_gap(); end

      // Random sweep.
      si_cur = 0; ce_cur = 1;
      repeat (10000) begin
         if ($urandom_range(7) == 0) si_cur = !si_cur;
         if ($urandom_range(499) == 0) ce_cur = !ce_cur;
         cycle(si_cur, ce_cur);
      end

      // Asynchronous reset during the third CC cycle.
      found = 0;
      for (int i = 0; i < 200; i++) begin
         cycle(1, 1);
         if (cc_active) begin found = 1; break; end
      end
      check("wait_cc_start", 32'(found), 32'd1);
      if (found) begin
         cycle(1, 1);
         cycle(1, 1);
         check("third_cc_cycle", 32'(cc_active), 32'd1);
         rst = 1'b1;
         #1;
         check("async_rst_outputs", 32'({send_K, send_A, send_R, send_CC, cc_active}), 32'd0);
         model_reset();
         reset_hold(2);
         rst = 1'b0;
      end

      // cc_enable dropped mid-sequence.
      found = 0;
      for (int i = 0; i < 200; i++) begin
         cycle(0, 1);
         if (cc_active) begin found = 1; break; end
      end
      check("wait_cc_start2", 32'(found), 32'd1);
      len = 1;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0);
         if (cc_active) len++;
         else break;
      end
      check("cc_len_after_disable", 32'(len), 32'(CC_LEN));
      seen = 0;
      repeat (200) begin
         cycle(0, 0);
         if (cc_active) seen = 1;
      end
      check("no_cc_after_disable", 32'(seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
